// File: rtl/io_port_responder.sv
// Peripheral end of the CPU I/O port: TX FIFO for OUT bytes, holding register for IN bytes.
// Optional overflow trap FSM enabled by defining IO_OVERFLOW_TRAP_EN.
module io_port_responder #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              async_nreset,
  input  logic [WIDTH-1:0]  io_data_output,
  input  logic              io_write,
  output logic [WIDTH-1:0]  io_data_input,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow,
  input  logic              overflow_clear,
  output logic              trap_trigger
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;

  // A pop in the same cycle frees a slot, so a write into a full FIFO is still accepted.
  assign full       = (count == FULL_COUNT);
  assign out_valid  = (count != '0);
  assign pop        = out_valid & out_ready;
  assign push       = io_write & (~full | pop);
  assign drop       = io_write & full & ~pop;
  assign out_data   = mem[rd_ptr];
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= io_data_output;
    end
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A drop on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clear) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      in_ready      <= 1'b0;
      io_data_input <= '0;
    end else begin
      in_ready <= 1'b1;
      if (in_valid && in_ready) begin
        io_data_input <= in_data;
      end
    end
  end

`ifdef IO_OVERFLOW_TRAP_EN
  typedef enum logic {IDLE, ARMED} trap_state_t;

  trap_state_t trap_state;

  // Only the first drop after a clear raises a one-cycle trap pulse.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      trap_state   <= IDLE;
      trap_trigger <= 1'b0;
    end else begin
      trap_trigger <= 1'b0;
      case (trap_state)
        IDLE: begin
          if (drop) begin
            trap_state   <= ARMED;
            trap_trigger <= 1'b1;
          end
        end
        ARMED: begin
          if (overflow_clear && !drop) begin
            trap_state <= IDLE;
          end
        end
      endcase
    end
  end
`else
  assign trap_trigger = 1'b0;
`endif

endmodule
